// File: rtl/soc_onchip_mem_arbiter.sv
// Round-robin arbiter for two Avalon-MM masters sharing one single-port RAM, with in-order read return.
// Optional grant locking is compiled in when MEM_ARB_LOCK_EN is defined.
module soc_onchip_mem_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned LOCK_MAX     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic                  m0_lock,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic                  m1_lock,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  logic req0, req1;
  logic grant0, grant1;
  logic acc0, acc1, accept, winner;
  logic win_read;
  logic last_q, last_d;
  logic [READ_LATENCY-1:0] tag_vld_q, tag_own_q;
  logic rsp_vld, rsp_own;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef MEM_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  typedef enum logic [1:0] {StOpen, StLock0, StLock1} lock_state_e;
  lock_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic max_exit;
`else
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock ^ (LOCK_MAX == 0);
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      // last_q = 1 means m1 was served last, so m0 wins a tie
      if (req0 && req1) begin
        grant0 = last_q;
        grant1 = ~last_q;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
`ifdef MEM_ARB_LOCK_EN
      if (state_q == StLock0) begin
        grant0 = 1'b1;
        grant1 = 1'b0;
      end else if (state_q == StLock1) begin
        grant0 = 1'b0;
        grant1 = 1'b1;
      end
`endif
    end
  end

  assign acc0   = req0 & grant0;
  assign acc1   = req1 & grant1;
  assign accept = acc0 | acc1;
  assign winner = acc1;

  assign m0_waitrequest = ~grant0;
  assign m1_waitrequest = ~grant1;

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    win_read       = 1'b0;
    if (acc0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = m0_write;
      win_read       = m0_read & ~m0_write;
    end else if (acc1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
      win_read       = m1_read & ~m1_write;
    end
  end

  assign mem_chipselect = accept;
  assign mem_clken      = ~reset;

`ifdef MEM_ARB_LOCK_EN
  // cnt counts locked grants including the one that opened the lock
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    max_exit = 1'b0;
    unique case (state_q)
      StOpen: begin
        cnt_d = '0;
        if (LOCK_MAX > 1 && acc0 && m0_lock) begin
          state_d = StLock0;
          cnt_d   = CNT_W'(1);
        end else if (LOCK_MAX > 1 && acc1 && m1_lock) begin
          state_d = StLock1;
          cnt_d   = CNT_W'(1);
        end
      end
      StLock0, StLock1: begin
        if ((state_q == StLock0) ? !m0_lock : !m1_lock) begin
          state_d = StOpen;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(LOCK_MAX)) begin
            state_d  = StOpen;
            cnt_d    = '0;
            max_exit = 1'b1;
          end
        end
      end
      default: begin
        state_d = StOpen;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StOpen;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  always_comb begin
    last_d = accept ? winner : last_q;
`ifdef MEM_ARB_LOCK_EN
    if (max_exit) last_d = (state_q == StLock1);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q    <= 1'b1;
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      last_q       <= last_d;
      tag_vld_q[0] <= accept & win_read;
      tag_own_q[0] <= winner;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
      end
    end
  end

  assign rsp_vld = tag_vld_q[READ_LATENCY-1];
  assign rsp_own = tag_own_q[READ_LATENCY-1];

  assign m0_readdatavalid = rsp_vld & ~rsp_own;
  assign m1_readdatavalid = rsp_vld & rsp_own;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

endmodule

// File: tb/tb_soc_onchip_mem_arbiter.sv
// Bench for soc_onchip_mem_arbiter: RAM model, shadow-memory reference and per-cycle grant checks.
// Lock checks follow MEM_ARB_LOCK_EN when it is defined for the build.
module tb_soc_onchip_mem_arbiter;
  localparam int RL   = 3;
  localparam int LMAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m0_lock = 1'b0;
  logic        m1_read = 1'b0, m1_write = 1'b0, m1_lock = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  always #5 clk = ~clk;

  soc_onchip_mem_arbiter #(
    .ADDR_W(16), .DATA_W(32), .READ_LATENCY(RL), .LOCK_MAX(LMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  function automatic logic [31:0] init_val(input logic [15:0] a);
    if (a == 16'h0010) return 32'hDEADBEEF;
    if (a == 16'h0005) return 32'hAABBCCDD;
    return {a, ~a} ^ 32'h5A3C96E1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // RAM environment: registered read, extra pipeline stages up to RL
  logic [31:0] ram [0:65535];
  bit          ram_seen [0:65535];
  logic [31:0] rd_pipe [0:RL-1];
  logic [31:0] ram_cur;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      ram_cur = ram_seen[mem_address] ? ram[mem_address] : init_val(mem_address);
      if (mem_write) begin
        ram[mem_address]      <= merge(ram_cur, mem_byteenable, mem_writedata);
        ram_seen[mem_address] <= 1'b1;
      end else begin
        rd_pipe[0] <= ram_cur;
      end
    end
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_readdata = rd_pipe[RL-1];

  // Reference model state
  logic [31:0] shadow [0:65535];
  bit          sh_seen [0:65535];
  typedef struct {int owner; logic [31:0] data; int due;} rsp_t;
  rsp_t exp_q[$];
  int last_w = 1, lock_owner = -1, lock_run = 0, cyc = 0;
  int n_pass = 0, n_total = 0;

  function automatic logic [31:0] sh_read(input logic [15:0] a);
    return sh_seen[a] ? shadow[a] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic drive(input int n, input bit rd, input bit wr, input logic [15:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input bit lk);
    if (n == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be;
      m0_writedata = wd; m0_lock = lk;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be;
      m1_writedata = wd; m1_lock = lk;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 16'h0, 4'h0, 32'h0, 0);
    drive(1, 0, 0, 16'h0, 4'h0, 32'h0, 0);
  endtask

  // One clock of checking: inputs must already be applied
  task automatic cycle();
    bit r[2], wr[2], lk[2];
    logic [15:0] ad[2];
    logic [3:0] be[2];
    logic [31:0] wd[2];
    int g, acc;
    bit due0, due1;
    @(negedge clk);
    r[0] = m0_read | m0_write; r[1] = m1_read | m1_write;
    wr[0] = m0_write; wr[1] = m1_write; lk[0] = m0_lock; lk[1] = m1_lock;
    ad[0] = m0_address; ad[1] = m1_address; be[0] = m0_byteenable; be[1] = m1_byteenable;
    wd[0] = m0_writedata; wd[1] = m1_writedata;
    if (lock_owner >= 0) g = lock_owner;
    else if (r[0] && r[1]) g = 1 - last_w;
    else if (r[0]) g = 0;
    else if (r[1]) g = 1;
    else g = -1;
    acc = (g >= 0 && r[g]) ? g : -1;
    check("m0_waitrequest", 32'(m0_waitrequest), 32'(g != 0));
    check("m1_waitrequest", 32'(m1_waitrequest), 32'(g != 1));
    check("mem_chipselect", 32'(mem_chipselect), 32'(acc >= 0));
    check("mem_clken", 32'(mem_clken), 32'd1);
    if (acc >= 0) begin
      check("mem_address", 32'(mem_address), 32'(ad[acc]));
      check("mem_write", 32'(mem_write), 32'(wr[acc]));
      if (wr[acc]) begin
        check("mem_byteenable", 32'(mem_byteenable), 32'(be[acc]));
        check("mem_writedata", mem_writedata, wd[acc]);
      end
    end
    due0 = exp_q.size() > 0 && exp_q[0].due == cyc && exp_q[0].owner == 0;
    due1 = exp_q.size() > 0 && exp_q[0].due == cyc && exp_q[0].owner == 1;
    check("m0_readdatavalid", 32'(m0_readdatavalid), 32'(due0));
    check("m1_readdatavalid", 32'(m1_readdatavalid), 32'(due1));
    if (due0) check("m0_readdata", m0_readdata, exp_q[0].data);
    if (due1) check("m1_readdata", m1_readdata, exp_q[0].data);
    if (due0 || due1) void'(exp_q.pop_front());
    if (acc >= 0) begin
      if (wr[acc]) begin
        shadow[ad[acc]]  = merge(sh_read(ad[acc]), be[acc], wd[acc]);
        sh_seen[ad[acc]] = 1'b1;
      end else begin
        exp_q.push_back('{owner: acc, data: sh_read(ad[acc]), due: cyc + RL});
      end
      last_w = acc;
    end
`ifdef MEM_ARB_LOCK_EN
    if (lock_owner < 0) begin
      if (acc >= 0 && lk[acc]) begin
        lock_owner = acc;
        lock_run   = 1;
      end
    end else if (!lk[lock_owner]) begin
      lock_owner = -1;
    end else begin
      lock_run++;
      if (lock_run == LMAX) begin
        last_w     = lock_owner;
        lock_owner = -1;
      end
    end
`endif
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_reset(input int n);
    reset = 1'b1;
    #1;
    check("rst m0_waitrequest", 32'(m0_waitrequest), 32'd1);
    check("rst m1_waitrequest", 32'(m1_waitrequest), 32'd1);
    check("rst mem_chipselect", 32'(mem_chipselect), 32'd0);
    check("rst mem_clken", 32'(mem_clken), 32'd0);
    check("rst readdatavalid", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
    check("rst m0_readdata", m0_readdata, 32'd0);
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc += n;
    exp_q.delete();
    last_w = 1;
    lock_owner = -1;
    lock_run = 0;
  endtask

  initial begin
    idle();
    pulse_reset(2);

    // Single read from m0, m1 idle
    drive(0, 1, 0, 16'h0010, 4'hF, 32'h0, 0);
    cycle();
    idle();
    repeat (RL + 1) cycle();

    // Continuous contention after reset alternates m0, m1
    pulse_reset(1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 16'(8'h20 + i), 4'hF, 32'h0, 0);
      drive(1, 1, 0, 16'(8'h40 + i), 4'hF, 32'h0, 0);
      cycle();
    end
    idle();
    repeat (RL + 1) cycle();

    // Partial write then readback
    drive(1, 0, 1, 16'h0005, 4'b0011, 32'h00001234, 0);
    cycle();
    idle();
    drive(0, 1, 0, 16'h0005, 4'hF, 32'h0, 0);
    cycle();
    idle();
    repeat (RL + 1) cycle();

    // Back-to-back reads from both masters return in issue order
    drive(0, 1, 0, 16'h0100, 4'hF, 32'h0, 0);
    cycle();
    drive(0, 1, 0, 16'h0101, 4'hF, 32'h0, 0);
    cycle();
    idle();
    drive(1, 1, 0, 16'h0102, 4'hF, 32'h0, 0);
    cycle();
    idle();
    repeat (RL + 1) cycle();

    // Reset with a read in flight
    drive(0, 1, 0, 16'h0010, 4'hF, 32'h0, 0);
    cycle();
    idle();
    pulse_reset(1);
    repeat (RL + 2) cycle();
    drive(0, 1, 0, 16'h0003, 4'hF, 32'h0, 0);
    drive(1, 1, 0, 16'h0004, 4'hF, 32'h0, 0);
    cycle();
    idle();
    repeat (RL + 1) cycle();

    // Held lock from m0 against a persistent m1 request
    pulse_reset(1);
    drive(0, 1, 0, 16'h0030, 4'hF, 32'h0, 1);
    drive(1, 1, 0, 16'h0031, 4'hF, 32'h0, 0);
    repeat (12) cycle();
    idle();
    repeat (RL + 1) cycle();

    // Randomized traffic over a small address window
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        int op;
        op = $urandom_range(0, 3);
        drive(n, op == 1 || op == 3, op == 2, 16'($urandom_range(0, 31)),
              4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0);
      end
      cycle();
    end
    idle();
    repeat (RL + 2) cycle();
    check("responses drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
